// File: rtl/dk_sfx_trigger_ctrl.sv
// Sound-port sequencer: fractional-divider sample strobe plus per-channel gate
// state machines that enforce a minimum on-time and a re-trigger hold-off.
module dk_sfx_trigger_ctrl #(
  parameter int CLOCK_RATE       = 1000000,
  parameter int SAMPLE_RATE      = 48000,
  parameter int NUM_CH           = 4,
  parameter int MIN_HOLD_SAMPLES = 480,
  parameter int HOLDOFF_SAMPLES  = 96
) (
  input  logic              clk,
  input  logic              I_RSTn,
  input  logic              wr_stb,
  input  logic [1:0]        wr_addr,
  input  logic              wr_data,
  output logic              audio_clk_en,
  output logic [NUM_CH-1:0] sfx_en,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLDOFF} ch_state_t;

  localparam logic [31:0] SR     = 32'(SAMPLE_RATE);
  localparam logic [31:0] CR     = 32'(CLOCK_RATE);
  localparam logic [15:0] MIN16  = 16'(MIN_HOLD_SAMPLES);
  localparam logic [15:0] HOLD16 = 16'(HOLDOFF_SAMPLES);

  logic [31:0] acc_reg;
  logic [31:0] acc_sum;

  // acc stays below CLOCK_RATE, so the sum never overflows 32 bits
  assign acc_sum = acc_reg + SR;

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      acc_reg      <= '0;
      audio_clk_en <= 1'b0;
    end else if (acc_sum >= CR) begin
      acc_reg      <= acc_sum - CR;
      audio_clk_en <= 1'b1;
    end else begin
      acc_reg      <= acc_sum;
      audio_clk_en <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t   state_reg, state_next;
      logic [15:0] cnt_reg, cnt_next;
      logic        pend_off_reg, pend_off_next;
      logic        pend_on_reg, pend_on_next;
      logic        sfx_en_reg, busy_reg;
      logic        wr_hit, cnt_zero;

      assign wr_hit   = wr_stb && (wr_addr == 2'(gi));
      assign cnt_zero = (cnt_reg == 16'd0);

      // Loads are listed ahead of decrements, so a load always wins the cycle
      always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pend_off_next = pend_off_reg;
        pend_on_next  = pend_on_reg;
        case (state_reg)
          ST_IDLE: begin
            if (wr_hit && wr_data) begin
              state_next    = ST_ACTIVE;
              cnt_next      = MIN16;
              pend_off_next = 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (wr_hit && wr_data) begin
              cnt_next      = MIN16;
              pend_off_next = 1'b0;
            end else if (wr_hit && cnt_zero) begin
              state_next   = ST_HOLDOFF;
              cnt_next     = HOLD16;
              pend_on_next = 1'b0;
            end else if (wr_hit) begin
              pend_off_next = 1'b1;
            end else if (pend_off_reg && cnt_zero) begin
              state_next    = ST_HOLDOFF;
              cnt_next      = HOLD16;
              pend_on_next  = 1'b0;
              pend_off_next = 1'b0;
            end else if (audio_clk_en && !cnt_zero) begin
              cnt_next = cnt_reg - 16'd1;
            end
          end
          ST_HOLDOFF: begin
            if (wr_hit && wr_data) begin
              pend_on_next = 1'b1;
            end else if (wr_hit) begin
              pend_on_next = 1'b0;
            end else if (cnt_zero) begin
              if (pend_on_reg) begin
                state_next   = ST_ACTIVE;
                cnt_next     = MIN16;
                pend_on_next = 1'b0;
              end else begin
                state_next = ST_IDLE;
              end
            end else if (audio_clk_en) begin
              cnt_next = cnt_reg - 16'd1;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
          state_reg    <= ST_IDLE;
          cnt_reg      <= '0;
          pend_off_reg <= 1'b0;
          pend_on_reg  <= 1'b0;
          sfx_en_reg   <= 1'b0;
          busy_reg     <= 1'b0;
        end else begin
          state_reg    <= state_next;
          cnt_reg      <= cnt_next;
          pend_off_reg <= pend_off_next;
          pend_on_reg  <= pend_on_next;
          sfx_en_reg   <= (state_next == ST_ACTIVE);
          busy_reg     <= (state_next != ST_IDLE);
        end
      end

      assign sfx_en[gi] = sfx_en_reg;
      assign busy[gi]   = busy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dk_sfx_trigger_ctrl.sv
// Random-stimulus bench: two instances (4ch MIN=4 HOLD=2, 3ch MIN=0 HOLD=0)
// checked every cycle against a rule-level model plus literal pins.
module tb_dk_sfx_trigger_ctrl;

  localparam int CR = 1000000;
  localparam int SR = 48000;

  logic       clk = 1'b0;
  logic       I_RSTn = 1'b0;
  logic       wr_stb = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic       wr_data = 1'b0;

  logic       a_stb, b_stb;
  logic [3:0] a_sfx, a_busy;
  logic [2:0] b_sfx, b_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dk_sfx_trigger_ctrl #(.CLOCK_RATE(CR), .SAMPLE_RATE(SR), .NUM_CH(4),
                        .MIN_HOLD_SAMPLES(4), .HOLDOFF_SAMPLES(2)) dut_a (
    .clk(clk), .I_RSTn(I_RSTn), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .audio_clk_en(a_stb), .sfx_en(a_sfx), .busy(a_busy));

  dk_sfx_trigger_ctrl #(.CLOCK_RATE(CR), .SAMPLE_RATE(SR), .NUM_CH(3),
                        .MIN_HOLD_SAMPLES(0), .HOLDOFF_SAMPLES(0)) dut_b (
    .clk(clk), .I_RSTn(I_RSTn), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .audio_clk_en(b_stb), .sfx_en(b_sfx), .busy(b_busy));

  // Model state: 0 idle, 1 active, 2 holdoff; index [instance][channel]
  int  m_st  [2][4];
  int  m_cnt [2][4];
  bit  m_po  [2][4];
  bit  m_pn  [2][4];
  bit  m_stb;
  int  m_n;
  int  last_stb;
  int  win_cnt;

  function automatic int nch_of(input int k);  return (k == 0) ? 4 : 3; endfunction
  function automatic int min_of(input int k);  return (k == 0) ? 4 : 0; endfunction
  function automatic int hold_of(input int k); return (k == 0) ? 2 : 0; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        m_st[k][c] = 0; m_cnt[k][c] = 0; m_po[k][c] = 0; m_pn[k][c] = 0;
      end
    m_stb = 0; m_n = 0; last_stb = 0; win_cnt = 0;
  endtask

  task automatic model_step();
    bit hit;
    longint cur, prv;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < nch_of(k); c++) begin
        hit = wr_stb && (int'(wr_addr) == c);
        case (m_st[k][c])
          0: if (hit && wr_data) begin m_st[k][c] = 1; m_cnt[k][c] = min_of(k); m_po[k][c] = 0; end
          1: begin
            if (hit && wr_data) begin m_cnt[k][c] = min_of(k); m_po[k][c] = 0; end
            else if (hit && m_cnt[k][c] == 0) begin
              m_st[k][c] = 2; m_cnt[k][c] = hold_of(k); m_pn[k][c] = 0;
            end
            else if (hit) m_po[k][c] = 1;
            else if (m_po[k][c] && m_cnt[k][c] == 0) begin
              m_st[k][c] = 2; m_cnt[k][c] = hold_of(k); m_pn[k][c] = 0; m_po[k][c] = 0;
            end
            else if (m_stb && m_cnt[k][c] > 0) m_cnt[k][c]--;
          end
          default: begin
            if (hit && wr_data) m_pn[k][c] = 1;
            else if (hit) m_pn[k][c] = 0;
            else if (m_cnt[k][c] == 0) begin
              if (m_pn[k][c]) begin m_st[k][c] = 1; m_cnt[k][c] = min_of(k); m_pn[k][c] = 0; end
              else m_st[k][c] = 0;
            end
            else if (m_stb) m_cnt[k][c]--;
          end
        endcase
      end
    // Strobe after edge n iff floor(n*SR/CR) advanced
    m_n++;
    cur = (longint'(m_n) * SR) / CR;
    prv = (longint'(m_n - 1) * SR) / CR;
    m_stb = (cur > prv);
  endtask

  task automatic compare_all();
    logic [3:0] ea_sfx, ea_busy;
    logic [2:0] eb_sfx, eb_busy;
    for (int c = 0; c < 4; c++) begin
      ea_sfx[c] = (m_st[0][c] == 1); ea_busy[c] = (m_st[0][c] != 0);
    end
    for (int c = 0; c < 3; c++) begin
      eb_sfx[c] = (m_st[1][c] == 1); eb_busy[c] = (m_st[1][c] != 0);
    end
    check("a_stb", 32'(a_stb), 32'(m_stb));
    check("b_stb", 32'(b_stb), 32'(m_stb));
    check("a_sfx", 32'(a_sfx), 32'(ea_sfx));
    check("a_busy", 32'(a_busy), 32'(ea_busy));
    check("b_sfx", 32'(b_sfx), 32'(eb_sfx));
    check("b_busy", 32'(b_busy), 32'(eb_busy));
  endtask

  // Single compare process: model advances on each edge, outputs checked 1ns later
  always @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      model_reset();
      #1 compare_all();
    end else begin
      model_step();
      #1 compare_all();
      if (m_n == 20 || m_n == 21) check("first_stb_edge21", 32'(a_stb), 32'(m_n == 21));
      if (m_n == 42) check("second_stb_edge42", 32'(a_stb), 32'd1);
      if (a_stb) begin
        if (last_stb > 0)
          check("stb_gap_20_21", 32'((m_n - last_stb == 20) || (m_n - last_stb == 21)), 32'd1);
        last_stb = m_n;
        if (m_n <= 25000) win_cnt++;
      end
      if (m_n == 25000) check("stb_count_25k", 32'(win_cnt), 32'd1200);
    end
  end

  task automatic do_write(input int ch, input bit d);
    @(negedge clk);
    wr_stb = 1'b1; wr_addr = 2'(ch); wr_data = d;
    $display("[TB] write ch%0d=%0d before edge %0d", ch, d, m_n + 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_stb = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    I_RSTn = 1'b1;

    // Short press: gate rises one cycle after the write; MIN=0 instance releases at once
    do_write(0, 1'b1);
    @(posedge clk); #2;
    check("press_a_sfx0_rise", 32'(a_sfx[0]), 32'd1);
    check("press_b_sfx0_rise", 32'(b_sfx[0]), 32'd1);
    idle_cycles(1);
    do_write(0, 1'b0);
    @(posedge clk); #2;
    check("release_b_sfx0_same_edge", 32'(b_sfx[0]), 32'd0);
    check("release_a_sfx0_held", 32'(a_sfx[0]), 32'd1);
    idle_cycles(1);

    // Random traffic, including out-of-range index 3 for the 3-channel instance
    for (int i = 0; i < 26000; i++) begin
      if ($urandom_range(0, 39) == 0) do_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else idle_cycles(1);
    end
    idle_cycles(1);

    // Asynchronous reset between edges drops every gate immediately
    do_write(0, 1'b1);
    do_write(1, 1'b1);
    do_write(2, 1'b1);
    idle_cycles(1);
    @(posedge clk); #3;
    I_RSTn = 1'b0;
    #1;
    check("async_rst_a_sfx", 32'(a_sfx), 32'd0);
    check("async_rst_a_busy", 32'(a_busy), 32'd0);
    check("async_rst_b_sfx", 32'(b_sfx), 32'd0);
    repeat (2) @(negedge clk);
    I_RSTn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) do_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else idle_cycles(1);
    end
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dk_sfx_trigger_ctrl.md
# dk_sfx_trigger_ctrl

Sequencing controller for the discrete sound circuits. It generates the shared `audio_clk_en` sample strobe from the system clock using an exact fractional divider. It also converts CPU sound-port writes into per-channel enables (`walk_en`-style gates) for the discrete effect blocks. Each channel has a minimum-on time and a re-trigger hold-off, both measured in audio samples, so the downstream envelope, VCO and filter chains always see well-formed gates.

## Interface
- `CLOCK_RATE`, 1000000: clk frequency in Hz.
- `SAMPLE_RATE`, 48000: target `audio_clk_en` rate in Hz. Must be < `CLOCK_RATE`.
- `NUM_CH`, 4: number of effect channels, 1..4.
- `MIN_HOLD_SAMPLES`, 480: minimum gate-on time in samples, 0..65535.
- `HOLDOFF_SAMPLES`, 96: forced gate-off time after release, in samples, 0..65535.

Ports:
- `clk`, in, 1: system clock.
- `I_RSTn`, in, 1: asynchronous, active-low reset.
- `wr_stb`, in, 1: one-cycle CPU write strobe.
- `wr_addr`, in, 2: channel index. Writes to index ≥ `NUM_CH` are ignored.
- `wr_data`, in, 1: 1 = request on, 0 = request off.
- `audio_clk_en`, out, 1: sample strobe, high for one cycle.
- `sfx_en`, out, `NUM_CH`: per-channel gate to the effect blocks. Active high.
- `busy`, out, `NUM_CH`: channel state ≠ IDLE.

## Operation
**Fractional divider**
- 32-bit accumulator `acc`, reset 0.
- Each cycle: if `acc + SAMPLE_RATE >= CLOCK_RATE`, then `acc <= acc + SAMPLE_RATE - CLOCK_RATE` and assert `audio_clk_en`. Otherwise `acc <= acc + SAMPLE_RATE`.
- Equivalent statement: `audio_clk_en` is high after rising edge n (n = 1 is the first edge after reset release) iff floor(n·SR/CR) > floor((n−1)·SR/CR).
- Long-term rate is exact. Jitter is at most 1 clk.

**Per-channel state**
- Each channel holds a state (IDLE, ACTIVE, HOLDOFF), a 16-bit counter `cnt`, and flags `pend_off` and `pend_on`.
- `sfx_en[i]` is 1 only in ACTIVE.
- A "write" below means `wr_stb` asserted with `wr_addr == i`.

**IDLE**
- Write 1: go to ACTIVE with `cnt <= MIN_HOLD_SAMPLES` and `pend_off <= 0`.
- Write 0: ignored.

**ACTIVE** (first matching rule wins)
1. Write 1: re-trigger. Set `cnt <= MIN_HOLD_SAMPLES` and `pend_off <= 0`.
2. Write 0 with `cnt == 0`: go to HOLDOFF with `cnt <= HOLDOFF_SAMPLES` and `pend_on <= 0`.
3. Write 0 with `cnt != 0`: set `pend_off <= 1`.
4. `pend_off && cnt == 0`: go to HOLDOFF with `cnt <= HOLDOFF_SAMPLES`, `pend_on <= 0`, `pend_off <= 0`.
5. `audio_clk_en && cnt != 0`: `cnt <= cnt - 1`.

**HOLDOFF** (first matching rule wins)
1. Write 1: set `pend_on <= 1`.
2. Write 0: set `pend_on <= 0`.
3. `cnt == 0`: if `pend_on`, go to ACTIVE with `cnt <= MIN_HOLD_SAMPLES` and `pend_on <= 0`. Otherwise go to IDLE.
4. `audio_clk_en && cnt != 0`: `cnt <= cnt - 1`.

**Rules across states**
- A load always takes priority over a decrement in the same cycle.
- The counter never wraps below 0.
- Only one channel can be written per cycle. All other channels continue independently.

## Timing
- Reset values:
  - `acc = 0`, `audio_clk_en = 0`.
  - All channels IDLE, `cnt = 0`, `pend_off = 0`, `pend_on = 0`.
  - `sfx_en = 0`, `busy = 0`.
- Reset applied mid-operation drops every gate immediately (asynchronous). Pending requests are lost.
- All outputs are registered.
  - `sfx_en` and `busy` change on the edge that samples the qualifying write or counter condition.
  - A write 1 to an IDLE channel gives `sfx_en` high one cycle after the `wr_stb` cycle.
- `MIN_HOLD_SAMPLES = 0`: a write 0 in ACTIVE releases on the same edge.
- `HOLDOFF_SAMPLES = 0`: the channel spends exactly one clk in HOLDOFF.
- Minimum gate-on time is `MIN_HOLD_SAMPLES` strobes plus 1 clk, measured from the write to when `cnt` reaches 0.
- With CR = 1e6 and SR = 48000, the first strobe is after edge 21, then edge 42, then edge 63.

## Test plan
All scenarios use CR = 1000000, SR = 48000, NUM_CH = 4, MIN = 4, HOLDOFF = 2 unless stated.

1. **Divider:** release reset and run 1,000,000 clks → exactly 48000 strobes, each one cycle wide. First strobe after edge 21. Gaps are only 20 or 21 clks.
2. **Short press:** write ch0 = 1, then write ch0 = 0 two cycles later.
   - `sfx_en[0]` rises 1 cycle after the first write.
   - It stays high until 4 strobes have elapsed, then falls 1 clk after `cnt` reaches 0.
   - `busy[0]` stays high for 2 further strobes plus 1 clk, then falls.
3. **Re-trigger:** with ch1 ACTIVE and `cnt = 1`, write 1 in the same cycle as `audio_clk_en` → `cnt = 4` (load wins). `sfx_en[1]` stays continuously high.
4. **Hold-off queue:** in ch2 HOLDOFF, write 1 → `sfx_en[2]` stays 0 until `cnt = 0`, then rises on the next edge. `cnt = 4`.
   - Repeat with a write 1 followed by a write 0 inside HOLDOFF → the channel returns to IDLE.
5. **Independence and invalid address:** interleave writes to ch0 and ch3, plus a write to index 3 with NUM_CH = 3.
   - Channel timelines match single-channel runs.
   - The out-of-range write has no effect.
6. **Async reset mid-gate:** assert `I_RSTn = 0` between clock edges while 3 channels are ACTIVE → `sfx_en` and `busy` go to 0 immediately. After release, the divider restarts with its first strobe at edge 21.
